lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store sequencer for the CPU memory (M) stage.
- Takes the one-hot load/store info, address and store data from the M-stage register.
- Drives a single-outstanding request/grant/response data-memory bus, stalls the pipeline until the access completes, and returns aligned, extended load data.
- Flags misaligned accesses and bus timeouts as exceptions.

Parameters:
- TIMEOUT, 64: maximum cycles spent in REQ+WAIT before the access is aborted with a bus-timeout exception. Legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lsu_i_valid  in  1  M stage holds a valid instruction
- lsu_i_info  in  8  one-hot op: [0]lb [1]lh [2]lw [3]lbu [4]lhu [5]sb [6]sh [7]sw; 0 = not a memory op
- lsu_i_addr  in  32  byte address, ALU result
- lsu_i_wdata  in  32  store data, rs2
- lsu_o_stall  out  1  freeze pipeline stages up to and including M
- lsu_o_done  out  1  one-cycle pulse when the access finishes
- lsu_o_rdata  out  32  formatted load result, valid while lsu_o_done=1
- lsu_o_exc  out  1  exception pulse
- lsu_o_exc_code  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout
- dmem_o_req  out  1  bus request
- dmem_o_we  out  1  1 = write
- dmem_o_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_o_wdata  out  32  lane-replicated store data
- dmem_o_wstrb  out  4  byte enables; 0 for loads
- dmem_i_gnt  in  1  request accepted this cycle
- dmem_i_rvalid  in  1  response; also acts as the write acknowledge
- dmem_i_rdata  in  32  read word

Behaviour:
- All clk-related state is reset asynchronously by rst (active high).
- Reset values:
  - state = IDLE
  - dmem_o_req = 0, dmem_o_we = 0, dmem_o_addr = 0, dmem_o_wdata = 0, dmem_o_wstrb = 0
  - lsu_o_done = 0, lsu_o_rdata = 0, lsu_o_exc = 0, lsu_o_exc_code = 0
  - timeout counter = 0
- Alignment rules:
  - Misaligned when h-op and addr[0]=1, or w-op and addr[1:0]!=0.
  - info with more than one bit set is treated as "no op".
- IDLE:
  - If valid, info is one-hot and the access is aligned: latch op, addr and formatted wdata/wstrb, go to REQ.
  - lsu_o_stall = 1 combinationally during this IDLE cycle.
  - If valid, one-hot and misaligned: lsu_o_exc=1 combinationally with code 01 (load) or 10 (store), no bus activity, stall=0, stay in IDLE.
- REQ:
  - dmem_o_req=1; addr, we, wdata and wstrb are held stable until dmem_i_gnt=1.
  - On gnt go to WAIT; req drops on the next cycle.
- WAIT:
  - On dmem_i_rvalid, register the formatted rdata (loads) or 0 (stores), go to DONE.
  - An rvalid in the same cycle as gnt (while still in REQ) is legal and goes directly to DONE.
- DONE:
  - lsu_o_done=1 and stall=0 for exactly one cycle, then return to IDLE.
  - The pipeline advances on this edge, so IDLE then sees the next instruction; the same instruction is never reissued.
- Stall: lsu_o_stall = 1 in REQ and WAIT, as well as in the launching IDLE cycle described above.
- Timeout:
  - The counter clears on REQ entry and increments every cycle in REQ/WAIT.
  - When the count reaches TIMEOUT-1 without completion: go to DONE with lsu_o_exc=1, code 11, rdata=0, and dmem_o_req forced to 0.
  - A late rvalid arriving in IDLE is ignored.
- Store formatting:
  - sb: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0]
  - sh: wdata={2{wdata[15:0]}}, wstrb=addr[1] ? 4'b1100 : 4'b0011
  - sw: wdata and wstrb=4'b1111
- Load formatting:
  - sh = rdata >> (8*addr[1:0])
  - lb/lbu sign- or zero-extend bits [7:0]; lh/lhu extend bits [15:0]; lw passes all 32 bits.
- Reset mid-operation: immediate return to IDLE, req deasserted, no done or exc pulse.

Test Plan:
- lw at 0x100, gnt same cycle as req, rvalid 2 cycles later with rdata=0xDEADBEEF -> stall high 4 cycles; done pulse with rdata=0xDEADBEEF; dmem_o_addr=0x100, wstrb=0.
- lb at 0x203 with rdata=0x80FF1234, then lbu same address -> rdata=0xFFFFFF80, then 0x00000080.
- sh at 0x302 with wdata=0x0000ABCD, gnt held low 3 cycles -> req and addr=0x300 stable throughout; wdata=0xABCDABCD, wstrb=4'b1100; done after rvalid.
- lw at 0x101 -> exc=1, code=01 in the same cycle; no req; stall=0. sh at 0x001 -> exc=1, code=10.
- TIMEOUT=8, sw issued, gnt never asserted -> req drops after 8 cycles in REQ/WAIT; done and exc both pulse with code 11; stall released.
- rst asserted while in WAIT -> outputs return to reset values asynchronously; a subsequent rvalid is ignored and no done pulse occurs.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: M-stage load/store sequencer driving a single-outstanding req/gnt/rvalid data bus.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_i_valid,
  input  logic [7:0]  lsu_i_info,
  input  logic [31:0] lsu_i_addr,
  input  logic [31:0] lsu_i_wdata,
  output logic        lsu_o_stall,
  output logic        lsu_o_done,
  output logic [31:0] lsu_o_rdata,
  output logic        lsu_o_exc,
  output logic [1:0]  lsu_o_exc_code,
  output logic        dmem_o_req,
  output logic        dmem_o_we,
  output logic [31:0] dmem_o_addr,
  output logic [31:0] dmem_o_wdata,
  output logic [3:0]  dmem_o_wstrb,
  input  logic        dmem_i_gnt,
  input  logic        dmem_i_rvalid,
  input  logic [31:0] dmem_i_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic [4:0] ld_op;
  logic [1:0] off;
  logic to_flag;
  logic onehot, is_h, is_w, is_st, mis, launch, mis_exc, busy, done_ok, expire;
  logic [31:0] wdata_f, sh, fmt;
  logic [3:0] wstrb_f;
  always_comb begin
    onehot  = (lsu_i_info != 8'd0) && ((lsu_i_info & (lsu_i_info - 8'd1)) == 8'd0);
    is_h    = lsu_i_info[1] | lsu_i_info[4] | lsu_i_info[6];
    is_w    = lsu_i_info[2] | lsu_i_info[7];
    is_st   = |lsu_i_info[7:5];
    mis     = (is_h & lsu_i_addr[0]) | (is_w & (lsu_i_addr[1:0] != 2'b00));
    launch  = (state == IDLE) & lsu_i_valid & onehot & ~mis;
    mis_exc = (state == IDLE) & lsu_i_valid & onehot & mis;
    busy    = (state == REQ) | (state == WAIT);
    done_ok = ((state == REQ) & dmem_i_gnt & dmem_i_rvalid) | ((state == WAIT) & dmem_i_rvalid);
    // Completion in the final counted cycle wins over the timeout
    expire  = busy & (cnt == 8'(TIMEOUT - 1)) & ~done_ok;
    state_nxt = state == IDLE ? (launch ? REQ : IDLE) :
                state == REQ  ? ((done_ok | expire) ? DONE : dmem_i_gnt ? WAIT : REQ) :
                state == WAIT ? ((done_ok | expire) ? DONE : WAIT) : IDLE;
    wdata_f = lsu_i_info[5] ? {4{lsu_i_wdata[7:0]}} :
              lsu_i_info[6] ? {2{lsu_i_wdata[15:0]}} : lsu_i_wdata;
    wstrb_f = lsu_i_info[5] ? 4'b0001 << lsu_i_addr[1:0] :
              lsu_i_info[6] ? (lsu_i_addr[1] ? 4'b1100 : 4'b0011) :
              lsu_i_info[7] ? 4'b1111 : 4'b0000;
    sh  = dmem_i_rdata >> {off, 3'b000};
    fmt = ld_op[0] ? {{24{sh[7]}}, sh[7:0]} :
          ld_op[3] ? {24'd0, sh[7:0]} :
          ld_op[1] ? {{16{sh[15]}}, sh[15:0]} :
          ld_op[4] ? {16'd0, sh[15:0]} :
          ld_op[2] ? sh : 32'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ld_op        <= '0;
      off          <= '0;
      to_flag      <= 1'b0;
      dmem_o_we    <= 1'b0;
      dmem_o_addr  <= '0;
      dmem_o_wdata <= '0;
      dmem_o_wstrb <= '0;
      lsu_o_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        dmem_o_we    <= is_st;
        dmem_o_addr  <= {lsu_i_addr[31:2], 2'b00};
        dmem_o_wdata <= wdata_f;
        dmem_o_wstrb <= wstrb_f;
        ld_op        <= lsu_i_info[4:0];
        off          <= lsu_i_addr[1:0];
        cnt          <= '0;
        to_flag      <= 1'b0;
      end
      if (busy) cnt <= cnt + 8'd1;
      if (done_ok) lsu_o_rdata <= fmt;
      else if (expire) begin
        lsu_o_rdata <= '0;
        to_flag     <= 1'b1;
      end
    end
  end
  assign dmem_o_req     = state == REQ;
  assign lsu_o_done     = state == DONE;
  assign lsu_o_stall    = launch | busy;
  assign lsu_o_exc      = mis_exc | (lsu_o_done & to_flag);
  assign lsu_o_exc_code = mis_exc ? (is_st ? 2'b10 : 2'b01) : (lsu_o_done & to_flag) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench for lsu_mem_ctrl with TIMEOUT=8.
module tb_lsu_mem_ctrl;
  logic clk = 0, rst = 1;
  logic valid = 0;
  logic [7:0] info = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic stall, done, exc, req, we, gnt = 0, rvalid = 0;
  logic [31:0] rdata, daddr, dwdata, drdata = 0;
  logic [1:0] code;
  logic [3:0] wstrb;
  int n = 0, fails = 0;
  lsu_mem_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .lsu_i_valid(valid), .lsu_i_info(info), .lsu_i_addr(addr),
    .lsu_i_wdata(wdata), .lsu_o_stall(stall), .lsu_o_done(done), .lsu_o_rdata(rdata),
    .lsu_o_exc(exc), .lsu_o_exc_code(code), .dmem_o_req(req), .dmem_o_we(we),
    .dmem_o_addr(daddr), .dmem_o_wdata(dwdata), .dmem_o_wstrb(wstrb),
    .dmem_i_gnt(gnt), .dmem_i_rvalid(rvalid), .dmem_i_rdata(drdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gdly, input int rdly, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wd, input logic [3:0] exp_strb, input logic exp_we,
                        input logic [31:0] exp_rd);
    valid = 1; info = op; addr = a; wdata = wd; drdata = rd;
    #1;
    chk({tag, "_launch_stall"}, stall, 1);
    chk({tag, "_launch_noreq"}, req, 0);
    tick();
    chk({tag, "_wdata"}, dwdata, exp_wd);
    chk({tag, "_wstrb"}, wstrb, exp_strb);
    chk({tag, "_we"}, we, exp_we);
    for (int i = 0; i < gdly; i++) begin
      chk({tag, "_req_hold"}, req, 1);
      chk({tag, "_addr_hold"}, daddr, exp_addr);
      chk({tag, "_stall_req"}, stall, 1);
      tick();
    end
    gnt = 1;
    rvalid = (rdly == 0);
    chk({tag, "_req"}, req, 1);
    chk({tag, "_addr"}, daddr, exp_addr);
    tick();
    gnt = 0;
    if (rdly > 0) begin
      for (int i = 1; i < rdly; i++) begin
        chk({tag, "_wait_noreq"}, req, 0);
        chk({tag, "_wait_stall"}, stall, 1);
        tick();
      end
      rvalid = 1;
      #1;
      chk({tag, "_last_stall"}, stall, 1);
      tick();
    end
    rvalid = 0; valid = 0; info = 0;
    #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_exc"}, exc, 0);
    tick();
    chk({tag, "_done_drop"}, done, 0);
  endtask
  initial begin
    #2;
    chk("rst_req", req, 0);
    chk("rst_addr", daddr, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_done", done, 0);
    chk("rst_exc", exc, 0);
    chk("rst_rdata", rdata, 0);
    #10 rst = 0;
    tick();
    access("lw", 8'h04, 32'h100, 0, 32'hDEADBEEF, 0, 2, 32'h100, 0, 4'h0, 0, 32'hDEADBEEF);
    access("lb", 8'h01, 32'h203, 0, 32'h80FF1234, 0, 0, 32'h200, 0, 4'h0, 0, 32'hFFFFFF80);
    access("lbu", 8'h08, 32'h203, 0, 32'h80FF1234, 1, 1, 32'h200, 0, 4'h0, 0, 32'h00000080);
    access("sh", 8'h40, 32'h302, 32'h0000ABCD, 0, 3, 1, 32'h300, 32'hABCDABCD, 4'hC, 1, 0);
    access("sb", 8'h20, 32'h001, 32'h12345678, 0, 0, 1, 32'h000, 32'h78787878, 4'h2, 1, 0);
    access("lh", 8'h02, 32'h002, 0, 32'h80010000, 0, 1, 32'h000, 0, 4'h0, 0, 32'hFFFF8001);
    access("lhu", 8'h10, 32'h002, 0, 32'h80010000, 0, 1, 32'h000, 0, 4'h0, 0, 32'h00008001);
    // misaligned word load, then misaligned halfword store
    valid = 1; info = 8'h04; addr = 32'h101;
    #1;
    chk("mis_lw_exc", exc, 1);
    chk("mis_lw_code", code, 2'b01);
    chk("mis_lw_stall", stall, 0);
    tick();
    chk("mis_lw_noreq", req, 0);
    info = 8'h40; addr = 32'h001;
    #1;
    chk("mis_sh_exc", exc, 1);
    chk("mis_sh_code", code, 2'b10);
    tick();
    chk("mis_sh_noreq", req, 0);
    info = 8'h06; addr = 32'h100;
    #1;
    chk("multi_hot_stall", stall, 0);
    chk("multi_hot_exc", exc, 0);
    tick();
    chk("multi_hot_noreq", req, 0);
    // timeout: sw, no grant ever
    info = 8'h80; addr = 32'h40; wdata = 32'h11223344;
    #1;
    chk("to_launch_stall", stall, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_req", req, 1);
      tick();
    end
    valid = 0; info = 0;
    #1;
    chk("to_done", done, 1);
    chk("to_exc", exc, 1);
    chk("to_code", code, 2'b11);
    chk("to_rdata", rdata, 0);
    chk("to_req_drop", req, 0);
    chk("to_stall", stall, 0);
    tick();
    chk("to_idle_done", done, 0);
    chk("to_idle_exc", exc, 0);
    // reset while in WAIT
    valid = 1; info = 8'h04; addr = 32'h10; gnt = 1;
    tick();
    tick();
    gnt = 0;
    chk("rw_wait_stall", stall, 1);
    valid = 0; info = 0;
    #2 rst = 1;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_req", req, 0);
    chk("rw_addr", daddr, 0);
    chk("rw_done", done, 0);
    #1 rst = 0;
    tick();
    rvalid = 1; drdata = 32'hCAFEF00D;
    tick();
    rvalid = 0;
    chk("late_rv_done", done, 0);
    chk("late_rv_rdata", rdata, 0);
    tick();
    chk("late_rv_done2", done, 0);
    chk("late_rv_exc", exc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
